// File: rtl/mem_port_arbiter_pkg.sv
// Bundle: shared memory-interface types for the core's memory ports and the
// imem/dmem port arbiter.
package Bundle;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } MemoryWriteSignal;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ArbState;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } ArbOwner;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of arbitrations lost by the fetch port;
// force_imem is raised while the count sits at STARVE_MAX.
module arb_starve_counter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic force_imem
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CW'(STARVE_MAX))) begin
      count <= count + 1'b1;
    end
  end

  assign force_imem = (count == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes imem/dmem onto one single-ported memory, one
// transaction outstanding, dmem wins ties. MEM_ARB_FAIRNESS_EN adds a fetch starvation guard.
module mem_port_arbiter
  import Bundle::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_req_val,
  input  logic [AW-1:0]    imem_req_addr,
  output logic             imem_req_rdy,
  output logic             imem_resp_val,
  output logic [DW-1:0]    imem_resp_data,
  input  logic             dmem_req_val,
  input  logic [AW-1:0]    dmem_req_addr,
  input  logic [DW-1:0]    dmem_req_wdata,
  input  MemoryWriteSignal dmem_req_fcn,
  output logic             dmem_req_rdy,
  output logic             dmem_resp_val,
  output logic [DW-1:0]    dmem_resp_data,
  output logic             mem_req_val,
  output logic [AW-1:0]    mem_req_addr,
  output logic [DW-1:0]    mem_req_wdata,
  output MemoryWriteSignal mem_req_fcn,
  input  logic             mem_req_rdy,
  input  logic             mem_resp_val,
  input  logic [DW-1:0]    mem_resp_data,
  output logic             mem_stall
);

  ArbState state;
  ArbOwner owner;
  logic    grant_d;
  logic    grant_i;
  logic    force_imem;
  logic    resp_done;

  // The guard only overrides dmem when a fetch is actually waiting, so an
  // idle fetch port can never block a data access.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      grant_d = dmem_req_val & ~(force_imem & imem_req_val);
      grant_i = imem_req_val & ~grant_d;
    end
  end

  assign dmem_req_rdy = grant_d;
  assign imem_req_rdy = grant_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_IMEM;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_fcn   <= M_XRD;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner         <= OWN_DMEM;
            mem_req_addr  <= dmem_req_addr;
            mem_req_wdata <= dmem_req_wdata;
            mem_req_fcn   <= dmem_req_fcn;
            state         <= ISSUE;
          end else if (grant_i) begin
            owner         <= OWN_IMEM;
            mem_req_addr  <= imem_req_addr;
            mem_req_wdata <= '0;
            mem_req_fcn   <= M_XRD;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_rdy) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_val) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_req_val = (state == ISSUE);

  // Responses are routed only in WAIT; a stray mem_resp_val elsewhere is dropped.
  assign resp_done      = (state == WAIT) & mem_resp_val;
  assign imem_resp_val  = resp_done & (owner == OWN_IMEM);
  assign dmem_resp_val  = resp_done & (owner == OWN_DMEM);
  assign imem_resp_data = mem_resp_data;
  assign dmem_resp_data = mem_resp_data;

  assign mem_stall = ((state != IDLE) & ~resp_done) |
                     ((state == IDLE) & ((imem_req_val & ~grant_i) |
                                         (dmem_req_val & ~grant_d)));

`ifdef MEM_ARB_FAIRNESS_EN
  arb_starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inc       (grant_d & imem_req_val),
    .clr       (grant_i),
    .force_imem(force_imem)
  );
`else
  logic unused_starve_max;
  assign force_imem        = 1'b0;
  assign unused_starve_max = ^STARVE_MAX;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction-level reference of the arbitration rules.
module tb_mem_port_arbiter;
  import Bundle::*;

  localparam int unsigned AW         = 32;
  localparam int unsigned DW         = 32;
  localparam int unsigned STARVE_MAX = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
  localparam string EXP_ORDER = "DDDDIDDDDI";
`else
  localparam bit FAIR = 1'b0;
  localparam string EXP_ORDER = "DDDDDDDDDD";
`endif

  logic             clk;
  logic             reset;
  logic             imem_req_val;
  logic [AW-1:0]    imem_req_addr;
  logic             imem_req_rdy;
  logic             imem_resp_val;
  logic [DW-1:0]    imem_resp_data;
  logic             dmem_req_val;
  logic [AW-1:0]    dmem_req_addr;
  logic [DW-1:0]    dmem_req_wdata;
  MemoryWriteSignal dmem_req_fcn;
  logic             dmem_req_rdy;
  logic             dmem_resp_val;
  logic [DW-1:0]    dmem_resp_data;
  logic             mem_req_val;
  logic [AW-1:0]    mem_req_addr;
  logic [DW-1:0]    mem_req_wdata;
  MemoryWriteSignal mem_req_fcn;
  logic             mem_req_rdy;
  logic             mem_resp_val;
  logic [DW-1:0]    mem_resp_data;
  logic             mem_stall;

  int checks   = 0;
  int failures = 0;

  // Reference: one transaction in flight, split into "sent to memory" or not.
  bit               in_flight = 1'b0;
  bit               accepted  = 1'b0;
  bit               t_dmem    = 1'b0;
  logic [AW-1:0]    t_addr;
  logic [DW-1:0]    t_wdata;
  MemoryWriteSignal t_fcn;
  int               starve    = 0;
  string            glog      = "";

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_val  (imem_req_val),
    .imem_req_addr (imem_req_addr),
    .imem_req_rdy  (imem_req_rdy),
    .imem_resp_val (imem_resp_val),
    .imem_resp_data(imem_resp_data),
    .dmem_req_val  (dmem_req_val),
    .dmem_req_addr (dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_fcn  (dmem_req_fcn),
    .dmem_req_rdy  (dmem_req_rdy),
    .dmem_resp_val (dmem_resp_val),
    .dmem_resp_data(dmem_resp_data),
    .mem_req_val   (mem_req_val),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_fcn   (mem_req_fcn),
    .mem_req_rdy   (mem_req_rdy),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_data (mem_resp_data),
    .mem_stall     (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_req_val   = 1'b0;
    imem_req_addr  = '0;
    dmem_req_val   = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_wdata = '0;
    dmem_req_fcn   = M_XRD;
    mem_req_rdy    = 1'b0;
    mem_resp_val   = 1'b0;
    mem_resp_data  = '0;
  endtask

  // Inputs for this cycle are already applied; check, advance the reference, clock.
  task automatic tick();
    bit e_drdy, e_irdy, e_mval, e_iresp, e_dresp, e_stall, force_i;
    #1;
    e_drdy = 0; e_irdy = 0; e_mval = 0; e_iresp = 0; e_dresp = 0; e_stall = 0;
    if (!in_flight) begin
      force_i = FAIR && (starve >= int'(STARVE_MAX)) && imem_req_val;
      e_drdy  = dmem_req_val && !force_i;
      e_irdy  = imem_req_val && !e_drdy;
      e_stall = (dmem_req_val && !e_drdy) || (imem_req_val && !e_irdy);
    end else if (!accepted) begin
      e_mval  = 1;
      e_stall = 1;
    end else begin
      if (mem_resp_val) begin
        if (t_dmem) e_dresp = 1;
        else        e_iresp = 1;
      end
      e_stall = !mem_resp_val;
    end
    check("dmem_req_rdy", 64'(dmem_req_rdy), 64'(e_drdy));
    check("imem_req_rdy", 64'(imem_req_rdy), 64'(e_irdy));
    check("mem_req_val", 64'(mem_req_val), 64'(e_mval));
    check("imem_resp_val", 64'(imem_resp_val), 64'(e_iresp));
    check("dmem_resp_val", 64'(dmem_resp_val), 64'(e_dresp));
    check("mem_stall", 64'(mem_stall), 64'(e_stall));
    if (e_mval) begin
      check("mem_req_addr", 64'(mem_req_addr), 64'(t_addr));
      check("mem_req_fcn", 64'(mem_req_fcn), 64'(t_fcn));
      if (t_dmem) check("mem_req_wdata", 64'(mem_req_wdata), 64'(t_wdata));
    end
    if (e_iresp) check("imem_resp_data", 64'(imem_resp_data), 64'(mem_resp_data));
    if (e_dresp) check("dmem_resp_data", 64'(dmem_resp_data), 64'(mem_resp_data));

    if (!in_flight) begin
      if (e_drdy) begin
        in_flight = 1; accepted = 0; t_dmem = 1;
        t_addr = dmem_req_addr; t_wdata = dmem_req_wdata; t_fcn = dmem_req_fcn;
        if (FAIR && imem_req_val && starve < int'(STARVE_MAX)) starve++;
        glog = {glog, "D"};
      end else if (e_irdy) begin
        in_flight = 1; accepted = 0; t_dmem = 0;
        t_addr = imem_req_addr; t_fcn = M_XRD;
        starve = 0;
        glog = {glog, "I"};
      end
    end else if (!accepted) begin
      if (mem_req_rdy) accepted = 1;
    end else if (mem_resp_val) begin
      in_flight = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks reset values, releases it away from the edge.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rst_imem_req_rdy", 64'(imem_req_rdy), 64'd0);
    check("rst_dmem_req_rdy", 64'(dmem_req_rdy), 64'd0);
    check("rst_mem_req_val", 64'(mem_req_val), 64'd0);
    check("rst_resp_vals", {62'd0, imem_resp_val, dmem_resp_val}, 64'd0);
    check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    check("rst_mem_req_wdata", 64'(mem_req_wdata), 64'd0);
    check("rst_mem_req_fcn", 64'(mem_req_fcn), 64'd0);
    check("rst_mem_stall", 64'(mem_stall), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_flight = 0; accepted = 0; starve = 0;
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Single fetch to 0x100, memory accepts at once, data one cycle later.
    imem_req_val = 1'b1; imem_req_addr = 32'h100;
    tick();
    imem_req_val = 1'b0; mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0; mem_resp_val = 1'b1; mem_resp_data = 32'hDEADBEEF;
    #1;
    check("fetch_resp_val", 64'(imem_resp_val), 64'd1);
    check("fetch_resp_data", 64'(imem_resp_data), 64'hDEADBEEF);
    check("fetch_no_dmem_resp", 64'(dmem_resp_val), 64'd0);
    tick();
    idle_inputs();
    tick();

    // Simultaneous requests: dmem store first, fetch at the next IDLE.
    glog = "";
    imem_req_val = 1'b1; imem_req_addr = 32'h200;
    dmem_req_val = 1'b1; dmem_req_addr = 32'h40; dmem_req_wdata = 32'h55AA; dmem_req_fcn = M_XWR;
    tick();
    dmem_req_val = 1'b0; mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0; mem_resp_val = 1'b1; mem_resp_data = 32'h1234;
    tick();
    mem_resp_val = 1'b0;
    tick();
    imem_req_val = 1'b0; mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0; mem_resp_val = 1'b1; mem_resp_data = 32'hCAFE0001;
    tick();
    idle_inputs();
    checks++;
    assert (glog == "DI")
    else begin
      failures++;
      $error("FAIL tie_order: got %s expected DI", glog);
    end

    // Memory back-pressure for 5 cycles with both ports still requesting.
    dmem_req_val = 1'b1; dmem_req_addr = 32'h80; dmem_req_wdata = 32'hA5A5F00D; dmem_req_fcn = M_XWR;
    tick();
    imem_req_val = 1'b1; imem_req_addr = 32'h300;
    for (int unsigned i = 0; i < 5; i++) tick();
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0; mem_resp_val = 1'b1; mem_resp_data = 32'h0;
    tick();
    idle_inputs();
    tick();
    tick();

    // Continuous contention: grant order shows the starvation policy.
    do_reset();
    glog = "";
    imem_req_val = 1'b1; imem_req_addr = 32'h400;
    dmem_req_val = 1'b1; dmem_req_addr = 32'h44; dmem_req_fcn = M_XRD;
    mem_req_rdy = 1'b1; mem_resp_val = 1'b1; mem_resp_data = 32'h77;
    for (int unsigned i = 0; i < 60 && glog.len() < 10; i++) tick();
    checks++;
    assert (glog == EXP_ORDER)
    else begin
      failures++;
      $error("FAIL grant_order: got %s expected %s", glog, EXP_ORDER);
    end
    idle_inputs();
    tick();
    tick();

    // Reset while waiting for the response; the late response is dropped.
    imem_req_val = 1'b1; imem_req_addr = 32'h500;
    tick();
    imem_req_val = 1'b0; mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    tick();
    do_reset();
    mem_resp_val = 1'b1; mem_resp_data = 32'hBAD0BAD0;
    tick();
    mem_resp_val = 1'b0;
    tick();

    // Spurious responses in IDLE and ISSUE are ignored.
    mem_resp_val = 1'b1; mem_resp_data = 32'h11111111;
    tick();
    mem_resp_val = 1'b0;
    dmem_req_val = 1'b1; dmem_req_addr = 32'h90; dmem_req_fcn = M_XRD;
    tick();
    dmem_req_val = 1'b0; mem_resp_val = 1'b1;
    tick();
    mem_resp_val = 1'b0;
    #1;
    check("spurious_issue_hold", 64'(mem_req_val), 64'd1);
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0; mem_resp_val = 1'b1; mem_resp_data = 32'h22222222;
    tick();
    idle_inputs();
    tick();

    // Random traffic, including stray handshakes from the memory side.
    for (int unsigned i = 0; i < 600; i++) begin
      imem_req_val   = 1'($urandom_range(0, 1));
      imem_req_addr  = $urandom;
      dmem_req_val   = 1'($urandom_range(0, 1));
      dmem_req_addr  = $urandom;
      dmem_req_wdata = $urandom;
      dmem_req_fcn   = MemoryWriteSignal'(1'($urandom_range(0, 1)));
      mem_req_rdy    = 1'($urandom_range(0, 1));
      mem_resp_val   = ($urandom_range(0, 9) < 4);
      mem_resp_data  = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
